// File: rtl/tdc_stamp_fifo_pkg.sv
// tdc_pkg: shared constants for the timestamp capture path.
//   - edge_sel encodings per channel
//   - drop counter width
//   - helpers for channel-tag width and word field offsets
// Word layout, MSB first: {LOST, POL, CH, COARSE, FINE}.
package tdc_pkg;

  localparam int DROP_W = 16;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_e;

  // Channel tag is at least one bit wide so a single-channel build still has a field.
  function automatic int ch_w(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  function automatic int word_w(input int nch, input int fine_w, input int coarse_w);
    return 2 + ch_w(nch) + coarse_w + fine_w;
  endfunction

  // Field LSB offsets within the word.
  function automatic int coarse_lsb(input int fine_w);
    return fine_w;
  endfunction

  function automatic int ch_lsb(input int fine_w, input int coarse_w);
    return fine_w + coarse_w;
  endfunction

  function automatic int pol_bit(input int nch, input int fine_w, input int coarse_w);
    return fine_w + coarse_w + ch_w(nch);
  endfunction

  function automatic int lost_bit(input int nch, input int fine_w, input int coarse_w);
    return fine_w + coarse_w + ch_w(nch) + 1;
  endfunction

endpackage

// File: rtl/tdc_sfifo.sv
// tdc_sfifo: generic first-word-fall-through FIFO with occupancy output.
//   clk_i, rst_ni   clock, async active-low reset
//   wr_i, wdata_i   write request / data (accepted when not full, or when full and
//                   a read is popping in the same cycle)
//   rd_i            pop head word (ignored while empty)
//   rdata_o         head word while not empty, zero otherwise
//   empty_o, full_o, level_o   status
module tdc_sfifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             rd_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [LW-1:0]    level_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [LW-1:0]    cnt_q, cnt_d;
  logic             rd_eff, wr_eff;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == LW'(DEPTH));
  assign level_o = cnt_q;
  assign rdata_o = empty_o ? '0 : mem[rptr_q];

  assign rd_eff = rd_i & ~empty_o;
  assign wr_eff = wr_i & (~full_o | rd_eff);
  assign cnt_d  = cnt_q + LW'(wr_eff) - LW'(rd_eff);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_eff) wptr_q <= wptr_q + 1'b1;
      if (rd_eff) rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  // Storage carries no reset; rdata_o is masked while empty.
  always_ff @(posedge clk_i) begin
    if (wr_eff) mem[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/tdc_stamp_fifo.sv
// tdc_stamp_fifo: multi-channel edge timestamp capture into one shared FWFT FIFO.
//   clk_i, rst_ni   clock, async active-low reset
//   sig_i           synchronised channel levels
//   fine_i          per-channel fine codes, channel i at [i*FINE_W +: FINE_W]
//   edge_sel_i      per-channel 2-bit edge mode (off/rise/fall/both)
//   rd_i            pop head word
//   q_o             head word {LOST, POL, CH, COARSE, FINE}
//   empty_o, full_o, level_o   FIFO status
//   drop_cnt_o      saturating count of dropped events
//   rd_err_o        sticky: read attempted while empty
module tdc_stamp_fifo
  import tdc_pkg::*;
#(
  parameter int NCH      = 2,
  parameter int FINE_W   = 7,
  parameter int COARSE_W = 24,
  parameter int DEPTH    = 64,
  localparam int CH_W = ch_w(NCH),
  localparam int W    = word_w(NCH, FINE_W, COARSE_W),
  localparam int LW   = $clog2(DEPTH) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NCH-1:0]        sig_i,
  input  logic [NCH*FINE_W-1:0] fine_i,
  input  logic [2*NCH-1:0]      edge_sel_i,
  input  logic                  rd_i,
  output logic [W-1:0]          q_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic [LW-1:0]         level_o,
  output logic [DROP_W-1:0]     drop_cnt_o,
  output logic                  rd_err_o
);

  logic [COARSE_W-1:0]               coarse_q;
  logic                              armed_q;
  logic [CH_W-1:0]                   ptr_q, ptr_d, gidx;
  logic                              gv, wr_ok;
  logic [DROP_W-1:0]                 drop_q, drop_d;
  logic                              rd_err_q;
  logic [NCH-1:0]                    occ, lost, pol, edge_s, drop_s, gnt;
  logic [NCH-1:0][COARSE_W-1:0]      crs;
  logic [NCH-1:0][FINE_W-1:0]        fin;
  logic [W-1:0]                      wdata;

  // A write may happen if there is room, or a pop frees a slot this cycle.
  assign wr_ok = ~full_o | rd_i;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    edge_mode_e          mode;
    logic                rise, fall;
    logic                prev_q, occ_q, lost_q, pol_q;
    logic [COARSE_W-1:0] crs_q;
    logic [FINE_W-1:0]   fin_q;

    assign mode      = edge_mode_e'(edge_sel_i[2*i +: 2]);
    assign rise      = ~prev_q & sig_i[i] & ((mode == EDGE_RISE) | (mode == EDGE_BOTH));
    assign fall      = prev_q & ~sig_i[i] & ((mode == EDGE_FALL) | (mode == EDGE_BOTH));
    assign edge_s[i] = armed_q & (rise | fall);
    // Granted slot empties this cycle, so a new edge reloads it instead of dropping.
    assign drop_s[i] = edge_s[i] & occ_q & ~gnt[i];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        prev_q <= 1'b0;
        occ_q  <= 1'b0;
        lost_q <= 1'b0;
        pol_q  <= 1'b0;
        crs_q  <= '0;
        fin_q  <= '0;
      end else begin
        prev_q <= sig_i[i];
        if (edge_s[i] & ~drop_s[i]) begin
          occ_q <= 1'b1;
          pol_q <= sig_i[i];
          crs_q <= coarse_q;
          fin_q <= fine_i[i*FINE_W +: FINE_W];
        end else if (gnt[i]) begin
          occ_q <= 1'b0;
        end
        lost_q <= (lost_q & ~gnt[i]) | drop_s[i];
      end
    end

    assign occ[i]  = occ_q;
    assign lost[i] = lost_q;
    assign pol[i]  = pol_q;
    assign crs[i]  = crs_q;
    assign fin[i]  = fin_q;
  end

  // Round-robin search from ptr_q upward with wrap; first occupied slot wins.
  always_comb begin
    logic [CH_W:0] s;
    gv   = 1'b0;
    gidx = '0;
    s    = '0;
    for (int j = 0; j < NCH; j++) begin
      s = {1'b0, ptr_q} + (CH_W+1)'(j);
      if (s >= (CH_W+1)'(NCH)) s = s - (CH_W+1)'(NCH);
      if (!gv && occ[s[CH_W-1:0]]) begin
        gv   = 1'b1;
        gidx = s[CH_W-1:0];
      end
    end
    gv  = gv & wr_ok;
    gnt = '0;
    if (gv) gnt[gidx] = 1'b1;
    ptr_d = ptr_q;
    if (gv) ptr_d = (gidx == CH_W'(NCH-1)) ? '0 : gidx + 1'b1;
  end

  assign wdata = {lost[gidx], pol[gidx], gidx, crs[gidx], fin[gidx]};

  // Several channels can drop in one cycle; add them all, then saturate.
  always_comb begin
    logic [CH_W:0]   ndrop;
    logic [DROP_W:0] sum;
    ndrop = '0;
    for (int i = 0; i < NCH; i++) ndrop = ndrop + (CH_W+1)'(drop_s[i]);
    sum    = {1'b0, drop_q} + (DROP_W+1)'(ndrop);
    drop_d = sum[DROP_W] ? '1 : sum[DROP_W-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      coarse_q <= '0;
      armed_q  <= 1'b0;
      ptr_q    <= '0;
      drop_q   <= '0;
      rd_err_q <= 1'b0;
    end else begin
      coarse_q <= coarse_q + 1'b1;
      armed_q  <= 1'b1;
      ptr_q    <= ptr_d;
      drop_q   <= drop_d;
      if (rd_i & empty_o) rd_err_q <= 1'b1;
    end
  end

  assign drop_cnt_o = drop_q;
  assign rd_err_o   = rd_err_q;

  tdc_sfifo #(.WIDTH(W), .DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .wr_i    (gv),
    .wdata_i (wdata),
    .rd_i    (rd_i),
    .rdata_o (q_o),
    .empty_o (empty_o),
    .full_o  (full_o),
    .level_o (level_o)
  );

endmodule

// File: tb/tb_tdc_stamp_fifo.sv
// Directed bench for tdc_stamp_fifo. Coarse width is reduced so the wrap case
// is reachable in a short run; all other parameters are the defaults.
module tb_tdc_stamp_fifo;
  localparam int NCH = 2, FINE_W = 7, COARSE_W = 10, DEPTH = 64;
  localparam int W = 2 + 1 + COARSE_W + FINE_W;
  localparam int LW = $clog2(DEPTH) + 1;

  logic clk, rst_n, rd;
  logic [NCH-1:0] sig;
  logic [FINE_W-1:0] f0, f1;
  logic [2*NCH-1:0] edge_sel;
  logic [W-1:0] q;
  logic empty, full, rd_err;
  logic [LW-1:0] level;
  logic [15:0] drop_cnt;

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] held, w1, w2;
  int c, c2;

  tdc_stamp_fifo #(.NCH(NCH), .FINE_W(FINE_W), .COARSE_W(COARSE_W), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .sig_i(sig), .fine_i({f1, f0}), .edge_sel_i(edge_sel),
    .rd_i(rd), .q_o(q), .empty_o(empty), .full_o(full), .level_o(level),
    .drop_cnt_o(drop_cnt), .rd_err_o(rd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic l, input logic p, input logic ch,
                                      input int cr, input logic [FINE_W-1:0] f);
    logic [COARSE_W-1:0] crv;
    crv = COARSE_W'(cr);
    return {l, p, ch, crv, f};
  endfunction

  // Advance one cycle; inputs changed afterwards belong to the new cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc = (cyc + 1) % (1 << COARSE_W);
  endtask

  task automatic pop();
    rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    rst_n = 1'b0; rd = 1'b0; sig = '0; f0 = '0; f1 = '0; edge_sel = 4'b0001;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_q", 64'(q), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    chk("rst_rderr", 64'(rd_err), 64'd0);
    rst_n = 1'b1;
    cyc = 0;

    // Single rising edge on ch0 at coarse 100.
    while (cyc != 100) tick();
    sig = 2'b01; f0 = 7'h2A;
    tick(); tick();
    chk("t1_q", 64'(q), 64'(mk(0, 1, 0, 100, 7'h2A)));
    chk("t1_empty", 64'(empty), 64'd0);
    chk("t1_level", 64'(level), 64'd1);
    pop();
    chk("t1_drained", 64'(empty), 64'd1);

    // Simultaneous edges on both channels, ptr back at 0 after reset.
    sig = 2'b00; edge_sel = 4'b1111;
    do_reset();
    while (cyc != 500) tick();
    sig = 2'b11; f0 = 7'h11; f1 = 7'h22;
    tick(); tick(); tick();
    chk("t2_level", 64'(level), 64'd2);
    chk("t2_q0", 64'(q), 64'(mk(0, 1, 0, 500, 7'h11)));
    pop();
    chk("t2_q1", 64'(q), 64'(mk(0, 1, 1, 500, 7'h22)));
    pop();
    c2 = cyc;
    sig = 2'b00; f0 = 7'h33; f1 = 7'h44;
    tick(); tick(); tick();
    chk("t2b_q0", 64'(q), 64'(mk(0, 0, 0, c2, 7'h33)));
    pop();
    chk("t2b_q1", 64'(q), 64'(mk(0, 0, 1, c2, 7'h44)));
    pop();
    chk("t2b_empty", 64'(empty), 64'd1);

    // Fill: ch0 toggles every cycle, one word per cycle, no drops.
    for (int k = 0; k < DEPTH; k++) begin
      sig[0] = ~sig[0];
      f0 = 7'(k);
      exp_q.push_back(mk(0, sig[0], 0, cyc, 7'(k)));
      tick();
    end
    tick(); tick();
    chk("t3_full", 64'(full), 64'd1);
    chk("t3_level", 64'(level), 64'(DEPTH));
    chk("t3_nodrop", 64'(drop_cnt), 64'd0);

    // Three ch1 edges while full: first is held, the next two are lost.
    sig[1] = 1'b1; f1 = 7'h33;
    held = mk(1, 1, 1, cyc, 7'h33);
    tick();
    sig[1] = 1'b0; f1 = 7'h01;
    tick();
    sig[1] = 1'b1; f1 = 7'h02;
    tick();
    chk("t3_drop", 64'(drop_cnt), 64'd2);
    chk("t3_full2", 64'(full), 64'd1);
    chk("t3_head", 64'(q), 64'(exp_q.pop_front()));
    pop();
    exp_q.push_back(held);
    chk("t3_level_rd", 64'(level), 64'(DEPTH));

    // ch0 slot pending while full, then RD and write in the same cycle.
    sig[0] = ~sig[0]; f0 = 7'h55;
    w1 = mk(0, sig[0], 0, cyc, 7'h55);
    tick();
    chk("t4_level_pend", 64'(level), 64'(DEPTH));
    chk("t4_head", 64'(q), 64'(exp_q.pop_front()));
    pop();
    exp_q.push_back(w1);
    chk("t4_level", 64'(level), 64'(DEPTH));
    chk("t4_drop", 64'(drop_cnt), 64'd2);
    rd = 1'b1;
    for (int n = 0; n < DEPTH + 6 && exp_q.size() > 0; n++) begin
      chk("t4_drain", 64'(q), 64'(exp_q.pop_front()));
      tick();
    end
    rd = 1'b0;
    chk("t4_empty", 64'(empty), 64'd1);
    chk("t4_level0", 64'(level), 64'd0);

    // Coarse wrap across two consecutive ch0 edges.
    while (cyc != (1 << COARSE_W) - 1) tick();
    sig[0] = ~sig[0]; f0 = 7'h01;
    w1 = mk(0, sig[0], 0, cyc, 7'h01);
    tick();
    sig[0] = ~sig[0]; f0 = 7'h02;
    w2 = mk(0, sig[0], 0, 0, 7'h02);
    tick(); tick();
    chk("wrap_level", 64'(level), 64'd2);
    chk("wrap_q0", 64'(q), 64'(w1));
    pop();
    chk("wrap_q1", 64'(q), 64'(w2));
    pop();
    chk("wrap_drop", 64'(drop_cnt), 64'd2);

    // Read while empty.
    pop();
    chk("rderr", 64'(rd_err), 64'd1);
    chk("rderr_level", 64'(level), 64'd0);
    chk("rderr_empty", 64'(empty), 64'd1);

    // Reset mid-traffic with ten words queued.
    for (int k = 0; k < 10; k++) begin
      sig[0] = ~sig[0];
      tick();
    end
    tick(); tick();
    chk("t6_level10", 64'(level), 64'd10);
    #2;
    rst_n = 1'b0;
    sig = 2'b11;
    #1;
    chk("t6_empty", 64'(empty), 64'd1);
    chk("t6_level", 64'(level), 64'd0);
    chk("t6_drop", 64'(drop_cnt), 64'd0);
    chk("t6_q", 64'(q), 64'd0);
    chk("t6_rderr", 64'(rd_err), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    tick(); tick(); tick();
    chk("t6_unarmed", 64'(empty), 64'd1);
    chk("t6_unarmed_lvl", 64'(level), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
